// File: rtl/layer_sched_pkg.sv
// Shared types and helpers for the layer readout scheduler.
package layer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_READ    = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_e;

    // Hold setup counter covers HOLD_SETUP up to 255.
    localparam int HOLD_CNT_W = 8;
    // Group reset stretch counter covers RESET_MIN_CYCLES up to 65535.
    localparam int RST_CNT_W  = 16;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of reset groups; the last group may be partially populated.
    function automatic int num_groups(input int n, input int group_size);
        return (n + group_size - 1) / group_size;
    endfunction

    // Reset group that owns a given layer.
    function automatic int grp_of(input int idx, input int group_size);
        return idx / group_size;
    endfunction

endpackage

// File: rtl/layer_group_reset_stretch.sv
// Stretches the OR of a group's reset requests to a minimum pulse width.
// The output stays high while any request is high and for
// RESET_MIN_CYCLES cycles after the last request cycle.
module layer_group_reset_stretch
    import layer_sched_pkg::*;
#(
    parameter int GROUP_SIZE       = 4,
    parameter int RESET_MIN_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GROUP_SIZE-1:0] req_i,
    output logic                  group_reset_o
);

    logic [RST_CNT_W-1:0] cnt_q, cnt_d;
    logic                 active_q, active_d;

    // Reload on any request, otherwise count down and drop at zero.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (|req_i) begin
            cnt_d    = RST_CNT_W'(RESET_MIN_CYCLES - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == RST_CNT_W'(0)) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - RST_CNT_W'(1);
            end
        end else begin
            cnt_d = RST_CNT_W'(0);
        end
    end

    // Counter and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= RST_CNT_W'(0);
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign group_reset_o = active_q;

endmodule

// File: rtl/layer_readout_scheduler.sv
// Per-layer readout scheduler: synchronises layer interrupts, arbitrates
// round-robin, sequences hold/readout/release for one layer at a time and
// drives the stretched group reset lines.
module layer_readout_scheduler
    import layer_sched_pkg::*;
#(
    parameter int NUM_LAYERS       = 20,
    parameter int GROUP_SIZE       = 4,
    parameter int HOLD_SETUP       = 4,
    parameter int RESET_MIN_CYCLES = 16,
    parameter int SYNC_STAGES      = 2,
    localparam int NUM_GROUPS      = num_groups(NUM_LAYERS, GROUP_SIZE),
    localparam int LW              = idx_width(NUM_LAYERS)
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [NUM_LAYERS-1:0] layer_interruptn,
    input  logic [NUM_LAYERS-1:0] layer_enable,
    input  logic [NUM_LAYERS-1:0] layer_reset_req,
    output logic [NUM_GROUPS-1:0] group_reset,
    output logic [NUM_LAYERS-1:0] layer_hold,
    output logic                  rd_req,
    output logic [LW-1:0]         rd_layer,
    input  logic                  rd_done,
    output logic                  rd_abort,
    output logic                  busy
);

    localparam int PAD_W = NUM_GROUPS * GROUP_SIZE;

    logic [NUM_LAYERS-1:0] sync_q [SYNC_STAGES];
    logic [PAD_W-1:0]      req_pad_s;
    logic [NUM_GROUPS-1:0] group_reset_s;
    logic [NUM_LAYERS-1:0] layer_grst_s;
    logic [NUM_LAYERS-1:0] pending_s;
    logic                  grant_valid_s;
    logic [LW-1:0]         grant_idx_s;

    sched_state_e          state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LW-1:0]         rd_layer_q, rd_layer_d;
    logic [LW-1:0]         ptr_q, ptr_d;
    logic [NUM_LAYERS-1:0] layer_hold_q, layer_hold_d;
    logic                  rd_req_q, rd_req_d;
    logic                  rd_abort_q, rd_abort_d;
    logic                  busy_q, busy_d;

    // Layer index base+off, wrapped modulo NUM_LAYERS.
    function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_LAYERS) begin
            sum = sum - NUM_LAYERS;
        end else begin
            sum = sum;
        end
        return LW'(sum);
    endfunction

    // Interrupt synchroniser chain, idling high (no interrupt).
    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= layer_interruptn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Pad the request vector so every group sees a full-width slice.
    always_comb begin
        req_pad_s                 = '0;
        req_pad_s[NUM_LAYERS-1:0] = layer_reset_req;
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        layer_group_reset_stretch #(
            .GROUP_SIZE      (GROUP_SIZE),
            .RESET_MIN_CYCLES(RESET_MIN_CYCLES)
        ) u_stretch (
            .clk_i        (sysclk),
            .rst_i        (rst),
            .req_i        (req_pad_s[g*GROUP_SIZE +: GROUP_SIZE]),
            .group_reset_o(group_reset_s[g])
        );
    end

    // Fan each group reset out to its member layers and form pending.
    always_comb begin
        layer_grst_s = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_grst_s[i] = group_reset_s[grp_of(i, GROUP_SIZE)];
        end
        pending_s = layer_enable & ~sync_q[SYNC_STAGES-1] & ~layer_grst_s;
    end

    // Round-robin search starting at ptr_q; first pending layer wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (!grant_valid_s && pending_s[wrap_add(ptr_q, k)]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = wrap_add(ptr_q, k);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Next-state and registered-output decode for the readout sequence.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rd_layer_d   = rd_layer_q;
        ptr_d        = ptr_q;
        layer_hold_d = layer_hold_q;
        rd_req_d     = rd_req_q;
        rd_abort_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_d      = ST_HOLD;
                    rd_layer_d   = grant_idx_s;
                    ptr_d        = (grant_idx_s == LW'(NUM_LAYERS - 1)) ? LW'(0)
                                                                        : grant_idx_s + LW'(1);
                    layer_hold_d = NUM_LAYERS'(1) << grant_idx_s;
                    hold_cnt_d   = HOLD_CNT_W'(0);
                end else begin
                    layer_hold_d = '0;
                    rd_req_d     = 1'b0;
                end
            end
            ST_HOLD: begin
                if (layer_grst_s[rd_layer_q]) begin
                    state_d      = ST_RELEASE;
                    layer_hold_d = '0;
                    rd_req_d     = 1'b0;
                    rd_abort_d   = 1'b1;
                end else if (hold_cnt_q == HOLD_CNT_W'(HOLD_SETUP - 1)) begin
                    state_d  = ST_READ;
                    rd_req_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
                end
            end
            ST_READ: begin
                // A group reset beats a completion arriving in the same cycle.
                if (layer_grst_s[rd_layer_q]) begin
                    state_d      = ST_RELEASE;
                    layer_hold_d = '0;
                    rd_req_d     = 1'b0;
                    rd_abort_d   = 1'b1;
                end else if (rd_done) begin
                    state_d      = ST_RELEASE;
                    layer_hold_d = '0;
                    rd_req_d     = 1'b0;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RELEASE: begin
                state_d      = ST_IDLE;
                layer_hold_d = '0;
                rd_req_d     = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                layer_hold_d = '0;
                rd_req_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= HOLD_CNT_W'(0);
            rd_layer_q   <= LW'(0);
            ptr_q        <= LW'(0);
            layer_hold_q <= '0;
            rd_req_q     <= 1'b0;
            rd_abort_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_layer_q   <= rd_layer_d;
            ptr_q        <= ptr_d;
            layer_hold_q <= layer_hold_d;
            rd_req_q     <= rd_req_d;
            rd_abort_q   <= rd_abort_d;
            busy_q       <= busy_d;
        end
    end

    assign group_reset = group_reset_s;
    assign layer_hold  = layer_hold_q;
    assign rd_req      = rd_req_q;
    assign rd_layer    = rd_layer_q;
    assign rd_abort    = rd_abort_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_layer_readout_scheduler.sv
// Self-checking bench for layer_readout_scheduler: directed scenarios plus
// a randomized run against a timestamp-based reference model.
module tb_layer_readout_scheduler;

    localparam int N   = 20;
    localparam int GS  = 4;
    localparam int HS  = 4;
    localparam int MIN = 16;
    localparam int S   = 2;
    localparam int NG  = 5;
    localparam int LW  = 5;

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  layer_interruptn = '1;
    logic [N-1:0]  layer_enable = '1;
    logic [N-1:0]  layer_reset_req = '0;
    logic          rd_done = 1'b0;
    logic [NG-1:0] group_reset;
    logic [N-1:0]  layer_hold;
    logic          rd_req;
    logic [LW-1:0] rd_layer;
    logic          rd_abort;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sysclk = ~sysclk;

    layer_readout_scheduler #(
        .NUM_LAYERS(N), .GROUP_SIZE(GS), .HOLD_SETUP(HS),
        .RESET_MIN_CYCLES(MIN), .SYNC_STAGES(S)
    ) dut (
        .sysclk(sysclk), .rst(rst), .layer_interruptn(layer_interruptn),
        .layer_enable(layer_enable), .layer_reset_req(layer_reset_req),
        .group_reset(group_reset), .layer_hold(layer_hold), .rd_req(rd_req),
        .rd_layer(rd_layer), .rd_done(rd_done), .rd_abort(rd_abort), .busy(busy)
    );

    // Reference model: tracks the granted layer by timestamps (hold-rise
    // cycle, release cycle) and group resets by their last high cycle.
    int            m_cyc;
    logic [N-1:0]  m_q [S];
    int            m_gend [NG];
    bit            m_act;
    int            m_h, m_rel, m_abort, m_layer, m_ptr;
    logic [N-1:0]  m_pend;
    bit            m_found;
    int            m_idx;
    logic [N-1:0]  exp_hold;
    logic          exp_rd_req, exp_busy, exp_abort;
    logic [LW-1:0] exp_layer;
    logic [NG-1:0] exp_grst;

    initial begin
        m_cyc = 0; m_act = 0; m_layer = 0; m_ptr = 0; m_abort = -100; m_h = 0; m_rel = -1;
        for (int s = 0; s < S; s++) m_q[s] = '1;
        for (int g = 0; g < NG; g++) m_gend[g] = -100;
        forever begin
            @(posedge sysclk);
            m_cyc++;
            if (rst) begin
                m_act = 0; m_layer = 0; m_ptr = 0; m_abort = -100; m_rel = -1;
                for (int s = 0; s < S; s++) m_q[s] = '1;
                for (int g = 0; g < NG; g++) m_gend[g] = -100;
            end else begin
                for (int i = 0; i < N; i++)
                    m_pend[i] = layer_enable[i] & ~m_q[S-1][i] & ~((m_cyc - 1) <= m_gend[i / GS]);
                if (m_act) begin
                    if (m_rel >= 0) begin
                        if (m_cyc == m_rel + 1) m_act = 0;
                    end else if ((m_cyc - 1) <= m_gend[m_layer / GS]) begin
                        m_rel = m_cyc; m_abort = m_cyc;
                    end else if (rd_done && (m_cyc - 1 >= m_h + HS)) begin
                        m_rel = m_cyc;
                    end
                end else if (m_pend != '0) begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        m_idx = (m_ptr + k) % N;
                        if (!m_found && m_pend[m_idx]) begin m_found = 1; m_layer = m_idx; end
                    end
                    m_ptr = (m_layer + 1) % N;
                    m_act = 1; m_h = m_cyc; m_rel = -1;
                end
                for (int i = 0; i < N; i++)
                    if (layer_reset_req[i]) m_gend[i / GS] = m_cyc + MIN - 1;
                for (int s = S - 1; s > 0; s--) m_q[s] = m_q[s-1];
                m_q[0] = layer_interruptn;
            end
            exp_busy   = m_act;
            exp_hold   = (m_act && m_rel < 0) ? (N'(1) << m_layer) : '0;
            exp_rd_req = m_act && (m_rel < 0) && (m_cyc >= m_h + HS);
            exp_abort  = (m_cyc == m_abort);
            exp_layer  = LW'(m_layer);
            for (int g = 0; g < NG; g++) exp_grst[g] = (m_cyc <= m_gend[g]);
        end
    end

    // Waits (at negedges) for a condition: 0 hold nonzero, 1 rd_req high,
    // 2 busy low. Returns cycles waited, or -1 if the bound expires.
    task automatic wait_for(input int which, output int cycles);
        bit hit;
        cycles = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge sysclk);
            hit = (which == 0) ? (layer_hold != '0) : (which == 1) ? rd_req : !busy;
            if (hit) begin cycles = c; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        n_checks++; if (group_reset !== '0) begin n_errors++; $display("FAIL reset_group_reset: got %b want 0", group_reset); end
        n_checks++; if (layer_hold !== '0) begin n_errors++; $display("FAIL reset_hold: got %h want 0", layer_hold); end
        n_checks++; if ({rd_req, rd_abort, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_ctrl: got req/abort/busy %b want 000", {rd_req, rd_abort, busy}); end
        n_checks++; if (rd_layer !== '0) begin n_errors++; $display("FAIL reset_rd_layer: got %0d want 0", rd_layer); end
    endtask

    task automatic test_two_layers();
        int c;
        layer_interruptn[3] = 1'b0; layer_interruptn[17] = 1'b0;
        wait_for(0, c);
        n_checks++; if (c !== S + 1) begin n_errors++; $display("FAIL irq_to_hold_latency: got %0d want %0d", c, S + 1); end
        n_checks++; if (layer_hold !== (N'(1) << 3)) begin n_errors++; $display("FAIL first_grant_hold: got %h want %h", layer_hold, N'(1) << 3); end
        wait_for(1, c);
        n_checks++; if (c !== HS) begin n_errors++; $display("FAIL hold_to_req: got %0d want %0d", c, HS); end
        n_checks++; if (rd_layer !== LW'(3)) begin n_errors++; $display("FAIL first_rd_layer: got %0d want 3", rd_layer); end
        rd_done = 1'b1; layer_interruptn[3] = 1'b1;
        @(negedge sysclk); rd_done = 1'b0;
        n_checks++; if ({layer_hold != '0, rd_req, busy} !== 3'b001) begin n_errors++; $display("FAIL release_phase: got hold/req/busy %b want 001", {layer_hold != '0, rd_req, busy}); end
        @(negedge sysclk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_after_release: got %b want 0", busy); end
        wait_for(0, c);
        n_checks++; if (c !== 1) begin n_errors++; $display("FAIL next_grant_latency: got %0d want 1", c); end
        n_checks++; if (rd_layer !== LW'(17) || layer_hold !== (N'(1) << 17)) begin n_errors++; $display("FAIL second_grant: got layer %0d hold %h want 17", rd_layer, layer_hold); end
        wait_for(1, c);
        rd_done = 1'b1; layer_interruptn[17] = 1'b0 ^ 1'b1;
        @(negedge sysclk); rd_done = 1'b0;
        wait_for(2, c);
        n_checks++; if (c < 0) begin n_errors++; $display("FAIL two_layers_idle: got timeout want idle"); end
    endtask

    task automatic test_wrap();
        int c;
        layer_interruptn[19] = 1'b0;
        wait_for(1, c);
        n_checks++; if (rd_layer !== LW'(19)) begin n_errors++; $display("FAIL wrap_first: got %0d want 19", rd_layer); end
        layer_interruptn[0] = 1'b0;
        repeat (3) @(negedge sysclk);
        rd_done = 1'b1; layer_interruptn[19] = 1'b1;
        @(negedge sysclk); rd_done = 1'b0;
        wait_for(1, c);
        n_checks++; if (rd_layer !== LW'(0) || c < 0) begin n_errors++; $display("FAIL wrap_second: got %0d want 0", rd_layer); end
        rd_done = 1'b1; layer_interruptn[0] = 1'b1;
        @(negedge sysclk); rd_done = 1'b0;
        wait_for(2, c);
    endtask

    task automatic test_disabled();
        int bad;
        bad = 0;
        layer_enable[5] = 1'b0; layer_interruptn[5] = 1'b0;
        repeat (20) begin
            @(negedge sysclk);
            if (busy !== 1'b0 || layer_hold !== '0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL disabled_layer: got %0d busy cycles want 0", bad); end
        layer_interruptn[5] = 1'b1;
        repeat (S + 2) @(negedge sysclk);
        layer_enable[5] = 1'b1;
    endtask

    task automatic test_group_reset();
        int hi, other;
        hi = 0; other = 0;
        layer_reset_req[9] = 1'b1;
        @(negedge sysclk); layer_reset_req[9] = 1'b0;
        n_checks++; if (group_reset[2] !== 1'b1) begin n_errors++; $display("FAIL grst_rise: got %b want 1", group_reset[2]); end
        for (int k = 1; k <= 30; k++) begin
            if (group_reset[2]) hi++;
            if ((group_reset & ~NG'(4)) != '0) other++;
            @(negedge sysclk);
        end
        n_checks++; if (hi !== MIN) begin n_errors++; $display("FAIL grst_single_width: got %0d want %0d", hi, MIN); end
        n_checks++; if (other !== 0) begin n_errors++; $display("FAIL grst_other_groups: got %0d want 0", other); end
        hi = 0;
        for (int k = 0; k <= 45; k++) begin
            layer_reset_req[9] = (k == 0 || k == 10);
            @(negedge sysclk);
            if (group_reset[2]) hi++;
        end
        layer_reset_req[9] = 1'b0;
        n_checks++; if (hi !== 26) begin n_errors++; $display("FAIL grst_extended_width: got %0d want 26", hi); end
    endtask

    task automatic test_abort();
        int c, early, seen;
        early = 0; seen = 0;
        layer_interruptn[6] = 1'b0;
        wait_for(1, c);
        n_checks++; if (rd_layer !== LW'(6) || c < 0) begin n_errors++; $display("FAIL abort_setup: got %0d want 6", rd_layer); end
        layer_reset_req[4] = 1'b1;
        @(negedge sysclk);
        layer_reset_req[4] = 1'b0; rd_done = 1'b1;
        n_checks++; if (group_reset[1] !== 1'b1 || layer_hold !== (N'(1) << 6)) begin n_errors++; $display("FAIL abort_pre: got grst %b hold %h want 1/%h", group_reset[1], layer_hold, N'(1) << 6); end
        @(negedge sysclk); rd_done = 1'b0;
        n_checks++; if ({rd_abort, rd_req, layer_hold != '0} !== 3'b100) begin n_errors++; $display("FAIL abort_pulse: got abort/req/hold %b want 100", {rd_abort, rd_req, layer_hold != '0}); end
        @(negedge sysclk);
        n_checks++; if (rd_abort !== 1'b0) begin n_errors++; $display("FAIL abort_single: got %b want 0", rd_abort); end
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge sysclk);
            if (layer_hold != '0 && group_reset[1]) early++;
            if (layer_hold == (N'(1) << 6)) seen = 1;
        end
        n_checks++; if (early !== 0 || seen !== 1) begin n_errors++; $display("FAIL abort_regrant: got early %0d seen %0d want 0/1", early, seen); end
        wait_for(1, c);
        rd_done = 1'b1; layer_interruptn[6] = 1'b1;
        @(negedge sysclk); rd_done = 1'b0;
        wait_for(2, c);
    endtask

    task automatic test_reset_mid_read();
        int c;
        layer_interruptn[11] = 1'b0;
        wait_for(1, c);
        layer_interruptn[2] = 1'b0; layer_interruptn[15] = 1'b0;
        rst = 1'b1;
        @(negedge sysclk); rst = 1'b0;
        n_checks++; if ({layer_hold != '0, rd_req, rd_abort, busy, group_reset != '0, rd_layer != '0} !== 6'b0) begin
            n_errors++; $display("FAIL mid_read_reset: got hold=%h req=%b busy=%b layer=%0d want all 0", layer_hold, rd_req, busy, rd_layer); end
        wait_for(0, c);
        n_checks++; if (rd_layer !== LW'(2)) begin n_errors++; $display("FAIL ptr_after_reset: got %0d want 2", rd_layer); end
        layer_interruptn = '1;
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 1500; c++) begin
            @(negedge sysclk);
            n_checks++; if (layer_hold !== exp_hold) begin n_errors++; $display("FAIL rnd_hold cyc %0d: got %h want %h", c, layer_hold, exp_hold); end
            n_checks++; if (rd_req !== exp_rd_req) begin n_errors++; $display("FAIL rnd_rd_req cyc %0d: got %b want %b", c, rd_req, exp_rd_req); end
            n_checks++; if (rd_layer !== exp_layer) begin n_errors++; $display("FAIL rnd_rd_layer cyc %0d: got %0d want %0d", c, rd_layer, exp_layer); end
            n_checks++; if (busy !== exp_busy) begin n_errors++; $display("FAIL rnd_busy cyc %0d: got %b want %b", c, busy, exp_busy); end
            n_checks++; if (rd_abort !== exp_abort) begin n_errors++; $display("FAIL rnd_abort cyc %0d: got %b want %b", c, rd_abort, exp_abort); end
            n_checks++; if (group_reset !== exp_grst) begin n_errors++; $display("FAIL rnd_group_reset cyc %0d: got %b want %b", c, group_reset, exp_grst); end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) layer_interruptn[i] = ~layer_interruptn[i];
            if ($urandom_range(0, 63) == 0) begin r = $urandom_range(0, N - 1); layer_enable[r] = ~layer_enable[r]; end
            layer_reset_req = '0;
            if ($urandom_range(0, 39) == 0) begin r = $urandom_range(0, N - 1); layer_reset_req[r] = 1'b1; end
            rd_done = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 499) == 0);
        end
        rd_done = 1'b0; rst = 1'b0; layer_reset_req = '0;
    endtask

    initial begin
        test_reset();
        test_two_layers();
        test_wrap();
        test_disabled();
        test_group_reset();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_readout_scheduler.md
# layer_readout_scheduler

Parametrised per-layer readout scheduler and group-reset controller for the AstroPix row/layer array. It sits between the board-level layer pins and the SPI readout engine inside the detector top. It synchronises the active-low layer interrupts and arbitrates among pending layers round-robin. It sequences hold, readout and release for one layer at a time, and generates the stretched shared reset line for each group of layers.

## Interface
- NUM_LAYERS, 20, number of layers/rows (1..64)
- GROUP_SIZE, 4, layers sharing one reset line; NUM_GROUPS = ceil(NUM_LAYERS/GROUP_SIZE); last group may be partial
- HOLD_SETUP, 4, cycles hold is asserted before rd_req (1..255)
- RESET_MIN_CYCLES, 16, minimum group reset pulse width (1..65535)
- SYNC_STAGES, 2, interrupt synchroniser depth (>=2)

Ports:
- sysclk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- layer_interruptn  in  NUM_LAYERS  asynchronous layer interrupts, active low
- layer_enable  in  NUM_LAYERS  config mask; 0 = layer never granted
- layer_reset_req  in  NUM_LAYERS  per-layer reset request, level, active high
- group_reset  out  NUM_GROUPS  shared layer reset, active high
- layer_hold  out  NUM_LAYERS  hold, one-hot or zero
- rd_req  out  1  readout request to SPI engine
- rd_layer  out  $clog2(NUM_LAYERS) (min 1)  granted layer index, stable while rd_req high
- rd_done  in  1  readout engine completion, single-cycle pulse
- rd_abort  out  1  one-cycle pulse when an in-flight readout is cancelled
- busy  out  1  FSM not in IDLE

## Operation
- pending[i] = enable[i] & ~sync(interruptn[i]) & ~group_reset[grp(i)], with grp(i) = i / GROUP_SIZE.
- Round-robin arbiter: search begins at ptr and wraps modulo NUM_LAYERS. After each grant, ptr becomes grant+1, wrapping to 0 when grant = NUM_LAYERS-1.
- FSM:
  - IDLE: if any pending, latch the grant into rd_layer and go to HOLD. Otherwise stay in IDLE.
  - HOLD: layer_hold[rd_layer]=1 and the counter counts HOLD_SETUP cycles, then go to READ.
  - READ: rd_req=1 and hold stays high. rd_done=1 goes to RELEASE.
  - RELEASE: hold=0 and rd_req=0 for one cycle, then go to IDLE.
- Abort: if group_reset of the granted group is high in HOLD or READ, go to RELEASE next cycle and pulse rd_abort in that same transition cycle. Abort takes priority over a simultaneous rd_done.
- rd_done outside READ is ignored.
- Group reset: any layer_reset_req in group g loads counter g with RESET_MIN_CYCLES-1 and sets group_reset[g]. The output stays high while any request in the group is high, and until the counter reaches 0. A request re-asserted during stretching reloads the counter.
- Interrupts deasserting during HOLD/READ do not cancel the grant.

## Timing
- Reset values: group_reset=0, layer_hold=0, rd_req=0, rd_layer=0, rd_abort=0, busy=0, ptr=0, state IDLE, sync flops=1 (idle high).
- Interrupt to pending latency: SYNC_STAGES cycles.
- Pending to hold latency: 1 cycle, registered in IDLE.
- Hold rise to rd_req rise: exactly HOLD_SETUP cycles.
- rd_done sampled at cycle t: hold and rd_req are low at t+1, busy low at t+2, and a next grant is possible at t+2.
- Minimum per-layer turnaround: HOLD_SETUP+3 cycles.
- group_reset rises 1 cycle after the request rises. It falls RESET_MIN_CYCLES cycles after rise for a single-cycle request, or RESET_MIN_CYCLES cycles after request release if longer.
- All outputs registered.

## Structure
- Shared package layer_sched_pkg: state enum (IDLE, HOLD, READ, RELEASE), function grp_of(), constant width helpers.
- Sub-module layer_group_reset_stretch (one instance per group, params GROUP_SIZE/RESET_MIN_CYCLES).
- Arbiter and FSM stay inline.

## Test plan
- Layers 3 and 17 interrupt low simultaneously, ptr=0: grants 3 then 17. Hold on 3 precedes rd_req by 4 cycles, and rd_layer=3 then 17.
- Only layer 19 pending, then layer 0: ptr wraps, grant 0 after 19.
- layer_enable[5]=0 with interrupt 5 low: no hold, busy stays 0.
- layer_reset_req[9] one-cycle pulse: group_reset[2] high exactly 16 cycles. A re-pulse at cycle 10 extends it to cycle 26.
- Group 1 reset during READ of layer 6: rd_abort pulse, hold drops next cycle. A simultaneous rd_done is ignored and layer 6 is not re-granted until the reset ends.
- rst asserted mid-READ: all outputs 0 next cycle, ptr=0, state IDLE.
